// File: rtl/bp_resolve.sv
// Execute-side branch resolution: carries fetch-time BTB predictions through F/D and D/E,
// checks them in E, redirects fetch, flushes the wrong path and feeds the BTB update port.
// Optional statistics counters (br_cnt, misp_cnt) are built when BP_STATS_EN is defined.
module bp_resolve #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic        PredF,
  input  logic [31:0] NPC_PredF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        IsBrE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  output logic [31:0] NPC,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] PCE,
  output logic        PredE,
  output logic [31:0] NPC_PredE,
  output logic        BranchE_upd,
  output logic [31:0] BrNPC_upd,
  output logic        MispredE
`ifdef BP_STATS_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] misp_cnt
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0] r_pc_p1;
  logic        r_pred_p1;
  logic [31:0] r_npc_pred_p1;
  logic        r_vld_p1;
  logic [31:0] r_pc_p2;
  logic        r_pred_p2;
  logic [31:0] r_npc_pred_p2;
  logic        r_vld_p2;

  logic        w_res;
  logic        w_pred_e;
  logic        w_misp;
  logic        w_tgt_bad;
  logic [31:0] w_corr_pc;
  logic [31:0] w_seq_pc_f;
  logic [31:0] w_seq_pc_e;

  // F/D and D/E registers; a flush wins over a stall and only kills the valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_p1       <= '0;
      r_pred_p1     <= 1'b0;
      r_npc_pred_p1 <= '0;
      r_vld_p1      <= 1'b0;
      r_pc_p2       <= '0;
      r_pred_p2     <= 1'b0;
      r_npc_pred_p2 <= '0;
      r_vld_p2      <= 1'b0;
    end else begin
      if (!StallF) begin
        r_pc_p1       <= PCF;
        r_pred_p1     <= PredF;
        r_npc_pred_p1 <= NPC_PredF;
        r_vld_p1      <= 1'b1;
      end
      if (!StallD) begin
        r_pc_p2       <= r_pc_p1;
        r_pred_p2     <= r_pred_p1;
        r_npc_pred_p2 <= r_npc_pred_p1;
        r_vld_p2      <= r_vld_p1;
      end
      if (w_misp) begin
        r_vld_p1 <= 1'b0;
        r_vld_p2 <= 1'b0;
      end
    end
  end

  // E-stage resolution; a stalled or invalid E slot never decides anything
  assign w_res      = r_vld_p2 & ~StallD;
  assign w_pred_e   = r_pred_p2 & r_vld_p2;
  assign w_tgt_bad  = r_npc_pred_p2 != BrNPC;
  assign w_misp     = w_res & ((IsBrE & BranchE & (~w_pred_e | w_tgt_bad))
                             | (IsBrE & ~BranchE & w_pred_e)
                             | (~IsBrE & w_pred_e));
  assign w_seq_pc_e = r_pc_p2 + 32'd4;
  assign w_seq_pc_f = PCF + 32'd4;
  assign w_corr_pc  = (BranchE & IsBrE) ? BrNPC : w_seq_pc_e;

  always_comb begin
    if (!rst_n)
      NPC = RESET_PC;
    else if (w_misp)
      NPC = w_corr_pc;
    else if (PredF)
      NPC = NPC_PredF;
    else
      NPC = w_seq_pc_f;
  end

  assign MispredE    = w_misp;
  assign FlushD      = w_misp;
  assign FlushE      = w_misp;
  assign PCE         = r_pc_p2;
  assign PredE       = w_pred_e;
  assign NPC_PredE   = r_npc_pred_p2;
  assign BranchE_upd = w_res & IsBrE & BranchE;
  assign BrNPC_upd   = BrNPC;

`ifdef BP_STATS_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_misp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= '0;
      r_misp_cnt <= '0;
    end else begin
      if (w_res & IsBrE)
        r_br_cnt <= sat_inc(r_br_cnt);
      if (w_misp)
        r_misp_cnt <= sat_inc(r_misp_cnt);
    end
  end

  assign br_cnt   = r_br_cnt;
  assign misp_cnt = r_misp_cnt;
`endif

`ifndef SYNTHESIS
  // Stalling F while D advances would duplicate the D instruction into E
  a_no_dup: assert property (@(posedge clk) disable iff (!rst_n) !(StallF && !StallD));
`endif

endmodule

// File: tb/tb_bp_resolve.sv
// Scoreboard bench for bp_resolve: each directed branch pushes its expected E-stage result
// when fetched and is compared when it resolves; also covers stalls, flushes and async reset.
module tb_bp_resolve;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FILL_PC  = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredF;
  logic [31:0] NPC_PredF;
  logic        StallF;
  logic        StallD;
  logic        IsBrE;
  logic        BranchE;
  logic [31:0] BrNPC;
  logic [31:0] NPC;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] PCE;
  logic        PredE;
  logic [31:0] NPC_PredE;
  logic        BranchE_upd;
  logic [31:0] BrNPC_upd;
  logic        MispredE;
`ifdef BP_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] misp_cnt;
`endif

  bp_resolve #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredF(PredF), .NPC_PredF(NPC_PredF),
    .StallF(StallF), .StallD(StallD), .IsBrE(IsBrE), .BranchE(BranchE), .BrNPC(BrNPC),
    .NPC(NPC), .FlushD(FlushD), .FlushE(FlushE), .PCE(PCE), .PredE(PredE),
    .NPC_PredE(NPC_PredE), .BranchE_upd(BranchE_upd), .BrNPC_upd(BrNPC_upd),
    .MispredE(MispredE)
`ifdef BP_STATS_EN
    , .br_cnt(br_cnt), .misp_cnt(misp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npcp;
    logic        isbr;
    logic        br;
    logic [31:0] brnpc;
    logic        misp;
    logic [31:0] npc;
    logic        upd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npcp;
    logic        misp;
    logic [31:0] npc;
    logic        upd;
    logic [31:0] brnpc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_f(input logic [31:0] pc, input logic pred, input logic [31:0] npcp);
    PCF       = pc;
    PredF     = pred;
    NPC_PredF = npcp;
  endtask

  task automatic idle_e();
    IsBrE   = 1'b0;
    BranchE = 1'b0;
    BrNPC   = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int nstall);
    exp_t e;
    StallF = 1'b0;
    StallD = 1'b0;
    drive_f(v.pc, v.pred, v.npcp);
    @(negedge clk);
    chk("npc_fetch", NPC, v.pred ? v.npcp : v.pc + 32'd4);
    e = '{pc: v.pc, pred: v.pred, npcp: v.npcp, misp: v.misp, npc: v.npc, upd: v.upd,
          brnpc: v.brnpc};
    sb.push_back(e);
    @(posedge clk); #1;
    drive_f(FILL_PC, 1'b0, 32'h0);
    @(posedge clk); #1;
    IsBrE   = v.isbr;
    BranchE = v.br;
    BrNPC   = v.brnpc;
    for (int i = 0; i < nstall; i++) begin
      StallF = 1'b1;
      StallD = 1'b1;
      @(negedge clk);
      chk("stall_misp", {31'b0, MispredE}, 32'd0);
      chk("stall_flush", {31'b0, FlushD}, 32'd0);
      chk("stall_upd", {31'b0, BranchE_upd}, 32'd0);
      chk("stall_pce", PCE, v.pc);
      @(posedge clk); #1;
    end
    StallF = 1'b0;
    StallD = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("pce", PCE, e.pc);
      chk("prede", {31'b0, PredE}, {31'b0, e.pred});
      chk("npc_prede", NPC_PredE, e.npcp);
      chk("misp", {31'b0, MispredE}, {31'b0, e.misp});
      chk("flushd", {31'b0, FlushD}, {31'b0, e.misp});
      chk("flushe", {31'b0, FlushE}, {31'b0, e.misp});
      chk("npc_e", NPC, e.npc);
      chk("upd", {31'b0, BranchE_upd}, {31'b0, e.upd});
      chk("upd_data", BrNPC_upd, e.brnpc);
    end
    @(posedge clk); #1;
    if (v.misp) begin
      // squashed slots would mispredict if still valid
      IsBrE   = 1'b1;
      BranchE = 1'b1;
      BrNPC   = 32'h44;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("squash_misp", {31'b0, MispredE}, 32'd0);
        chk("squash_upd", {31'b0, BranchE_upd}, 32'd0);
        chk("squash_prede", {31'b0, PredE}, 32'd0);
        chk("squash_npc", NPC, FILL_PC + 32'd4);
        @(posedge clk); #1;
      end
    end
    idle_e();
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, FILL_PC + 32'd4, 1'b1};
    vecs[1] = '{32'h104, 1'b0, 32'h000, 1'b1, 1'b1, 32'h040, 1'b1, 32'h040, 1'b1};
    vecs[2] = '{32'h108, 1'b1, 32'h300, 1'b1, 1'b0, 32'h300, 1'b1, 32'h10C, 1'b0};
    vecs[3] = '{32'h120, 1'b1, 32'h500, 1'b1, 1'b1, 32'h504, 1'b1, 32'h504, 1'b1};
    vecs[4] = '{32'h130, 1'b1, 32'h700, 1'b0, 1'b0, 32'h000, 1'b1, 32'h134, 1'b0};
    vecs[5] = '{32'h140, 1'b0, 32'h000, 1'b1, 1'b0, 32'h050, 1'b0, FILL_PC + 32'd4, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 1'b1, 32'h010, 1'b1, 1'b0, 32'h010, 1'b1, 32'h000, 1'b0};
    vecs[7] = '{32'h150, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, FILL_PC + 32'd4, 1'b0};

    rst_n  = 1'b0;
    StallF = 1'b0;
    StallD = 1'b0;
    drive_f(32'h0000_0900, 1'b1, 32'h0000_0A00);
    idle_e();
    #2;
    chk("rst_npc", NPC, RESET_PC);
    chk("rst_pce", PCE, 32'h0);
    chk("rst_prede", {31'b0, PredE}, 32'd0);
    chk("rst_npc_prede", NPC_PredE, 32'h0);
    chk("rst_misp", {31'b0, MispredE}, 32'd0);
    chk("rst_flush", {30'b0, FlushD, FlushE}, 32'd0);
    chk("rst_upd", {31'b0, BranchE_upd}, 32'd0);
`ifdef BP_STATS_EN
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_misp_cnt", misp_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    chk("rst_npc_held", NPC, RESET_PC);
    rst_n = 1'b1;
    drive_f(FILL_PC, 1'b0, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);
    run_vec('{32'h110, 1'b0, 32'h000, 1'b1, 1'b1, 32'h060, 1'b1, 32'h060, 1'b1}, 3);

    // asynchronous reset in the middle of a redirect
    drive_f(32'h104, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive_f(FILL_PC, 1'b0, 32'h0);
    @(posedge clk); #1;
    IsBrE   = 1'b1;
    BranchE = 1'b1;
    BrNPC   = 32'h40;
    #2;
    chk("pre_rst_misp", {31'b0, MispredE}, 32'd1);
    chk("pre_rst_npc", NPC, 32'h40);
    drive_f(32'h0000_0900, 1'b1, 32'h0000_0A00);
    rst_n = 1'b0;
    #1;
    chk("arst_npc", NPC, RESET_PC);
    chk("arst_misp", {31'b0, MispredE}, 32'd0);
    chk("arst_flush", {30'b0, FlushD, FlushE}, 32'd0);
    chk("arst_upd", {31'b0, BranchE_upd}, 32'd0);
    chk("arst_pce", PCE, 32'h0);
    chk("arst_prede", {31'b0, PredE}, 32'd0);
    chk("arst_npc_prede", NPC_PredE, 32'h0);
`ifdef BP_STATS_EN
    chk("arst_br_cnt", br_cnt, 32'd0);
    chk("arst_misp_cnt", misp_cnt, 32'd0);
`endif
    idle_e();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_f(FILL_PC, 1'b0, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    run_vec(vecs[0], 0);
    run_vec(vecs[3], 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
